// File: rtl/result_collector_nocasc_3a_if.sv
// Handshake bundle between the NOCASC_3A PE result path / host and the result collector.
// The master side drives the PE words and host controls; the slave side is the collector.
interface result_collector_nocasc_3a_if #(
    parameter int WORD_WIDTH = 17,
    parameter int WORD_COUNT = 8
);
    logic                             start_i;
    logic                             res_valid_i;
    logic [WORD_WIDTH-1:0]            RES_i;
    logic [WORD_WIDTH-1:0]            p_i;
    logic [WORD_WIDTH*WORD_COUNT-1:0] result_o;
    logic                             result_valid_o;
    logic                             result_ready_i;
    logic                             busy_o;
    logic                             overflow_o;

    modport master (
        output start_i, res_valid_i, RES_i, p_i, result_ready_i,
        input  result_o, result_valid_o, busy_o, overflow_o
    );

    modport slave (
        input  start_i, res_valid_i, RES_i, p_i, result_ready_i,
        output result_o, result_valid_o, busy_o, overflow_o
    );
endinterface

// File: rtl/result_collector_nocasc_3a.sv
// Collects the LSW-first result words of the last NOCASC_3A PE into a full-width product.
// Optional macro FINAL_SUB_EN adds a word-serial R-p final subtraction selected on entry to HOLD.
module result_collector_nocasc_3a #(
    parameter int WORD_WIDTH = 17,
    parameter int WORD_COUNT = 8
) (
    input  logic                     clock_i,
    input  logic                     reset_i,
    result_collector_nocasc_3a_if.slave bus
);
    localparam int CNT_WIDTH = $clog2(WORD_COUNT + 1);
    localparam int TOTAL_W   = WORD_WIDTH * WORD_COUNT;

    typedef enum logic [1:0] {IDLE, COLLECT, HOLD} state_t;

    state_t                 state_q, state_d;
    logic [CNT_WIDTH-1:0]   cnt_q;
    logic [TOTAL_W-1:0]     raw_q, raw_d;
    logic                   overflow_q;
    logic                   restart, accept, last;

    // A start in HOLD only counts when it coincides with the host handshake.
    assign restart = bus.start_i && (state_q != HOLD || bus.result_ready_i);
    assign accept  = (state_q == COLLECT) && bus.res_valid_i && !bus.start_i;
    assign last    = accept && (cnt_q == CNT_WIDTH'(WORD_COUNT - 1));

    always_ff @(posedge clock_i) begin
        if (reset_i) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start_i) state_d = COLLECT;
            COLLECT: begin
                if (bus.start_i) state_d = COLLECT;
                else if (last)   state_d = HOLD;
            end
            HOLD:    if (bus.result_ready_i) state_d = bus.start_i ? COLLECT : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        raw_d = raw_q;
        if (accept) raw_d[int'(cnt_q)*WORD_WIDTH +: WORD_WIDTH] = bus.RES_i;
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            cnt_q      <= '0;
            overflow_q <= 1'b0;
            raw_q      <= '0;
        end else begin
            raw_q <= raw_d;
            if (restart) begin
                cnt_q      <= '0;
                overflow_q <= 1'b0;
            end else if (accept) begin
                cnt_q <= cnt_q + 1'b1;
            end else if (bus.res_valid_i && state_q != COLLECT) begin
                overflow_q <= 1'b1;
            end
        end
    end

`ifdef FINAL_SUB_EN
    logic [TOTAL_W-1:0]  diff_q, diff_d, sel_q;
    logic                borrow_q;
    logic [WORD_WIDTH:0] sub_w;

    // Top bit of the extended subtraction is the borrow out of this word.
    assign sub_w = {1'b0, bus.RES_i} - {1'b0, bus.p_i} - {{WORD_WIDTH{1'b0}}, borrow_q};

    always_comb begin
        diff_d = diff_q;
        if (accept) diff_d[int'(cnt_q)*WORD_WIDTH +: WORD_WIDTH] = sub_w[WORD_WIDTH-1:0];
    end

    always_ff @(posedge clock_i) begin
        diff_q <= diff_d;
        if (reset_i) begin
            borrow_q <= 1'b0;
            sel_q    <= '0;
        end else begin
            if (restart)     borrow_q <= 1'b0;
            else if (accept) borrow_q <= sub_w[WORD_WIDTH];
            if (last)        sel_q    <= sub_w[WORD_WIDTH] ? raw_d : diff_d;
        end
    end

    assign bus.result_o = sel_q;
`else
    assign bus.result_o = raw_q;
`endif

    assign bus.result_valid_o = (state_q == HOLD);
    assign bus.busy_o         = (state_q == COLLECT);
    assign bus.overflow_o     = overflow_q;
endmodule

// File: tb/tb_result_collector_nocasc_3a.sv
// Directed self-checking bench for result_collector_nocasc_3a (W=17, N=4).
// Expectations track FINAL_SUB_EN when the bench is built with that macro.
module tb_result_collector_nocasc_3a;
    localparam int W  = 17;
    localparam int N  = 4;
    localparam int TW = W * N;

    logic clock_i = 1'b0;
    logic reset_i = 1'b0;
    int   n_chk   = 0;
    int   n_pass  = 0;

    result_collector_nocasc_3a_if #(.WORD_WIDTH(W), .WORD_COUNT(N)) bus ();

    result_collector_nocasc_3a #(.WORD_WIDTH(W), .WORD_COUNT(N)) dut (
        .clock_i (clock_i),
        .reset_i (reset_i),
        .bus     (bus.slave)
    );

    always #5 clock_i = ~clock_i;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clock_i);
        #1;
    endtask

    task automatic pulse_start();
        bus.start_i = 1'b1;
        step();
        bus.start_i = 1'b0;
    endtask

    // Feeds N words back to back; checks valid is still low just before the last word lands.
    task automatic feed(input string tag, input logic [TW-1:0] r, input logic [TW-1:0] p);
        for (int k = 0; k < N; k++) begin
            if (k == N - 1) chk({tag, "_early"}, bus.result_valid_o, 1'b0);
            bus.res_valid_i = 1'b1;
            bus.RES_i       = r[k*W +: W];
            bus.p_i         = p[k*W +: W];
            step();
        end
        bus.res_valid_i = 1'b0;
        bus.RES_i       = '0;
        bus.p_i         = '0;
    endtask

    task automatic handshake(input string tag);
        bus.result_ready_i = 1'b1;
        step();
        bus.result_ready_i = 1'b0;
        chk({tag, "_vld_drop"}, bus.result_valid_o, 1'b0);
    endtask

    logic [TW-1:0] r1234, rabcd, pz, pa, ra, rb, ea;

    initial begin
        r1234 = {17'h00004, 17'h00003, 17'h00002, 17'h00001};
        rabcd = {17'h0000D, 17'h0000C, 17'h0000B, 17'h0000A};
        pz    = '0;
        bus.start_i = 0; bus.res_valid_i = 0; bus.RES_i = 0; bus.p_i = 0; bus.result_ready_i = 0;

        reset_i = 1'b1;
        step(); step();
        reset_i = 1'b0;
        chk("rst_valid", bus.result_valid_o, 1'b0);
        chk("rst_busy", bus.busy_o, 1'b0);
        chk("rst_ovf", bus.overflow_o, 1'b0);
        chk("rst_result", bus.result_o, '0);

        // Consecutive words
        pulse_start();
        chk("t1_busy", bus.busy_o, 1'b1);
        feed("t1", r1234, pz);
        chk("t1_valid", bus.result_valid_o, 1'b1);
        chk("t1_busy_hold", bus.busy_o, 1'b0);
        chk("t1_result", bus.result_o, r1234);
        handshake("t1");

        // Gaps of 0, 3, 1 idle cycles
        pulse_start();
        for (int k = 0; k < N; k++) begin
            bus.res_valid_i = 1'b1;
            bus.RES_i = r1234[k*W +: W];
            step();
            bus.res_valid_i = 1'b0;
            if (k == 1) repeat (3) begin step(); chk("t2_gap_valid", bus.result_valid_o, 1'b0); end
            if (k == 2) begin step(); chk("t2_gap_valid", bus.result_valid_o, 1'b0); end
        end
        chk("t2_valid", bus.result_valid_o, 1'b1);
        chk("t2_result", bus.result_o, r1234);
        handshake("t2");

        // Backpressure with stray words in HOLD
        pulse_start();
        feed("t3", rabcd, pz);
        for (int c = 0; c < 5; c++) begin
            bus.res_valid_i = c[0] ? 1'b0 : 1'b1;
            bus.RES_i = 17'h1FFFF;
            bus.start_i = (c == 2);
            step();
        end
        bus.res_valid_i = 1'b0; bus.RES_i = '0; bus.start_i = 1'b0;
        chk("t3_valid_stable", bus.result_valid_o, 1'b1);
        chk("t3_result_stable", bus.result_o, rabcd);
        chk("t3_ovf", bus.overflow_o, 1'b1);
        handshake("t3");
        chk("t3_ovf_sticky", bus.overflow_o, 1'b1);
        pulse_start();
        chk("t3_ovf_clear", bus.overflow_o, 1'b0);
        feed("t3b", r1234, pz);
        chk("t3b_result", bus.result_o, r1234);

        // Handshake coinciding with start
        bus.result_ready_i = 1'b1; bus.start_i = 1'b1;
        step();
        bus.result_ready_i = 1'b0; bus.start_i = 1'b0;
        chk("t4_vld_drop", bus.result_valid_o, 1'b0);
        chk("t4_busy", bus.busy_o, 1'b1);
        feed("t4", rabcd, pz);
        chk("t4_result", bus.result_o, rabcd);
        handshake("t4");

        // Restart mid-collect with a word in the same cycle
        pulse_start();
        bus.res_valid_i = 1'b1;
        bus.RES_i = 17'h7; step();
        bus.RES_i = 17'h8; step();
        bus.RES_i = 17'h9; bus.start_i = 1'b1; step();
        bus.start_i = 1'b0; bus.res_valid_i = 1'b0;
        chk("t4r_busy", bus.busy_o, 1'b1);
        feed("t4r", r1234, pz);
        chk("t4r_result", bus.result_o, r1234);
        handshake("t4r");

        // Reset in the middle of an operation
        pulse_start();
        bus.res_valid_i = 1'b1;
        bus.RES_i = 17'h11; step();
        bus.RES_i = 17'h22; step();
        bus.res_valid_i = 1'b0;
        reset_i = 1'b1; step(); reset_i = 1'b0;
        chk("t5_busy", bus.busy_o, 1'b0);
        chk("t5_valid", bus.result_valid_o, 1'b0);
        chk("t5_ovf", bus.overflow_o, 1'b0);
        chk("t5_result", bus.result_o, '0);
        bus.res_valid_i = 1'b1; bus.RES_i = 17'h3; step(); bus.res_valid_i = 1'b0;
        chk("t5_ovf_idle", bus.overflow_o, 1'b1);
        pulse_start();
        chk("t5_ovf_clear", bus.overflow_o, 1'b0);
        feed("t5", rabcd, pz);
        chk("t5_result2", bus.result_o, rabcd);
        handshake("t5");

        // Final subtraction vectors
        pa = {17'h0, 17'h0, 17'h0, 17'h1FFFF};
        ra = {17'h0, 17'h0, 17'h1, 17'h0};
        rb = {17'h0, 17'h0, 17'h0, 17'h5};
`ifdef FINAL_SUB_EN
        ea = {17'h0, 17'h0, 17'h0, 17'h1};
`else
        ea = ra;
`endif
        pulse_start();
        feed("t6a", ra, pa);
        chk("t6a_result", bus.result_o, ea);
        handshake("t6a");
        pulse_start();
        feed("t6b", rb, pa);
        chk("t6b_result", bus.result_o, rb);
        handshake("t6b");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
